// File: rtl/clock_mode_ctrl.sv
// Alarm-clock sequencer: run/time-set/alarm-set mode FSM,
// counter-enable decode and ring/snooze buzzer FSM.
module clock_mode_ctrl #(
  parameter int RING_CYCLES   = 60,
  parameter int SNOOZE_CYCLES = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timeset,
  input  logic       alarmset,
  input  logic       minadv,
  input  logic       hrsadv,
  input  logic       alarmon,
  input  logic       snooze,
  input  logic       smax,
  input  logic       mmax,
  input  logic       hmax,
  input  logic       ahmax,
  input  logic       alarm_match,
  output logic       sen,
  output logic       tmen,
  output logic       then,
  output logic       tpmen,
  output logic       amen,
  output logic       ahen,
  output logic       apmen,
  output logic       disp_sel,
  output logic [1:0] mode,
  output logic       buzz
);

  localparam int RW = (RING_CYCLES > 1) ? $clog2(RING_CYCLES) : 1;
  localparam int SW = (SNOOZE_CYCLES > 1) ? $clog2(SNOOZE_CYCLES) : 1;
  localparam logic [RW-1:0] RING_LAST = RW'(RING_CYCLES - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_CYCLES - 1);

  typedef enum logic [1:0] {
    M_RUN  = 2'd0,
    M_TSET = 2'd1,
    M_ASET = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_RING = 2'd1,
    B_SNZ  = 2'd2
  } bstate_e;

  mode_e   mode_q, mode_d;
  bstate_e bst_q, bst_d;
  logic [RW-1:0] ring_ct_q, ring_ct_d;
  logic [SW-1:0] snz_ct_q, snz_ct_d;
  logic          match_q;
  logic          rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= M_RUN;
      bst_q     <= B_IDLE;
      ring_ct_q <= '0;
      snz_ct_q  <= '0;
      match_q   <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      bst_q     <= bst_d;
      ring_ct_q <= ring_ct_d;
      snz_ct_q  <= snz_ct_d;
      match_q   <= alarm_match;
    end
  end

  always_comb begin
    mode_d = M_RUN;
    if (timeset && !alarmset)
      mode_d = M_TSET;
    else if (alarmset && !timeset)
      mode_d = M_ASET;
  end

  assign rise = alarm_match & ~match_q;

  // Leaving RUN or disarming always wins over ring/snooze progress.
  always_comb begin
    bst_d     = bst_q;
    ring_ct_d = ring_ct_q;
    snz_ct_d  = snz_ct_q;
    if (!alarmon || mode_d != M_RUN) begin
      bst_d     = B_IDLE;
      ring_ct_d = '0;
      snz_ct_d  = '0;
    end else begin
      unique case (bst_q)
        B_IDLE: begin
          if (rise && mode_q == M_RUN) begin
            bst_d     = B_RING;
            ring_ct_d = '0;
          end
        end
        B_RING: begin
          if (snooze) begin
            bst_d     = B_SNZ;
            snz_ct_d  = '0;
            ring_ct_d = '0;
          end else if (ring_ct_q == RING_LAST) begin
            bst_d     = B_IDLE;
            ring_ct_d = '0;
          end else begin
            ring_ct_d = ring_ct_q + 1'b1;
          end
        end
        B_SNZ: begin
          if (snz_ct_q == SNZ_LAST) begin
            bst_d     = B_RING;
            ring_ct_d = '0;
            snz_ct_d  = '0;
          end else begin
            snz_ct_d = snz_ct_q + 1'b1;
          end
        end
        default: begin
          bst_d     = B_IDLE;
          ring_ct_d = '0;
          snz_ct_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    sen      = 1'b0;
    tmen     = 1'b0;
    then     = 1'b0;
    tpmen    = 1'b0;
    amen     = 1'b0;
    ahen     = 1'b0;
    apmen    = 1'b0;
    disp_sel = 1'b0;
    if (!rst) begin
      unique case (mode_q)
        M_TSET: begin
          tmen  = minadv;
          then  = hrsadv;
          tpmen = hrsadv & hmax;
        end
        M_ASET: begin
          sen      = 1'b1;
          tmen     = smax;
          then     = smax & mmax;
          tpmen    = smax & mmax & hmax;
          amen     = minadv;
          ahen     = hrsadv;
          apmen    = hrsadv & ahmax;
          disp_sel = 1'b1;
        end
        default: begin
          sen   = 1'b1;
          tmen  = smax;
          then  = smax & mmax;
          tpmen = smax & mmax & hmax;
        end
      endcase
    end
  end

  assign mode = mode_q;
  assign buzz = (bst_q == B_RING);

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: enable-decode table
// plus hand sequences for ring, snooze and abort paths.
module tb_clock_mode_ctrl;

  logic clk = 1'b0;
  logic rst, timeset, alarmset, minadv, hrsadv, alarmon, snooze;
  logic smax, mmax, hmax, ahmax, alarm_match;
  logic sen, tmen, then, tpmen, amen, ahen, apmen, disp_sel, buzz;
  logic [1:0] mode;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clock_mode_ctrl #(
    .RING_CYCLES  (4),
    .SNOOZE_CYCLES(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .timeset    (timeset),
    .alarmset   (alarmset),
    .minadv     (minadv),
    .hrsadv     (hrsadv),
    .alarmon    (alarmon),
    .snooze     (snooze),
    .smax       (smax),
    .mmax       (mmax),
    .hmax       (hmax),
    .ahmax      (ahmax),
    .alarm_match(alarm_match),
    .sen        (sen),
    .tmen       (tmen),
    .then       (then),
    .tpmen      (tpmen),
    .amen       (amen),
    .ahen       (ahen),
    .apmen      (apmen),
    .disp_sel   (disp_sel),
    .mode       (mode),
    .buzz       (buzz)
  );

  // in:  ts as mi hr sm mm hm ahm
  // exp: mode(2) sen tmen then tpmen amen ahen apmen disp
  typedef struct {
    logic [7:0] in;
    logic [9:0] exp;
  } vec_t;

  vec_t vt [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {mode, sen, tmen, then, tpmen, amen, ahen, apmen, disp_sel};
  endfunction

  task automatic chk_buzz(input string name, input logic e);
    check(name, {15'd0, buzz}, {15'd0, e});
  endtask

  task automatic restart_match();
    alarm_match = 1'b0;
    step();
    alarm_match = 1'b1;
    step();
  endtask

  initial begin
    vt[0]  = '{8'b0000_1110, 10'b00_1111_0000};
    vt[1]  = '{8'b0000_1000, 10'b00_1100_0000};
    vt[2]  = '{8'b0011_0111, 10'b00_1000_0000};
    vt[3]  = '{8'b1010_1110, 10'b01_0100_0000};
    vt[4]  = '{8'b1010_1110, 10'b01_0100_0000};
    vt[5]  = '{8'b1011_0111, 10'b01_0111_0000};
    vt[6]  = '{8'b1001_0000, 10'b01_0010_0000};
    vt[7]  = '{8'b1100_1110, 10'b00_1111_0000};
    vt[8]  = '{8'b0101_1001, 10'b10_1100_0111};
    vt[9]  = '{8'b0110_0001, 10'b10_1000_1001};
    vt[10] = '{8'b0111_1110, 10'b10_1111_1101};
    vt[11] = '{8'b0000_0000, 10'b00_1000_0000};

    rst = 1'b1;
    {timeset, alarmset, minadv, hrsadv} = 4'b0011;
    {smax, mmax, hmax, ahmax} = 4'b1111;
    alarmon = 1'b1;
    snooze = 1'b0;
    alarm_match = 1'b0;
    step();
    step();
    check("reset_outs", {6'd0, outs()}, 16'd0);
    chk_buzz("reset_buzz", 1'b0);

    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      {timeset, alarmset, minadv, hrsadv,
       smax, mmax, hmax, ahmax} = vt[i].in;
      step();
      check($sformatf("vec%0d", i), {6'd0, outs()}, {6'd0, vt[i].exp});
    end

    // single ring burst, persistent match must not retrigger
    {timeset, alarmset, minadv, hrsadv} = 4'b0000;
    {smax, mmax, hmax, ahmax} = 4'b0000;
    step();
    restart_match();
    for (int i = 0; i < 4; i++) begin
      chk_buzz($sformatf("ring%0d", i), 1'b1);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      chk_buzz($sformatf("noretrig%0d", i), 1'b0);
      step();
    end

    // snooze in second ring cycle
    restart_match();
    chk_buzz("snz_r0", 1'b1);
    step();
    chk_buzz("snz_r1", 1'b1);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_buzz($sformatf("snz_quiet%0d", i), 1'b0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      chk_buzz($sformatf("snz_rering%0d", i), 1'b1);
      step();
    end
    chk_buzz("snz_done", 1'b0);

    // snooze on the last ring cycle still snoozes
    restart_match();
    step();
    step();
    step();
    chk_buzz("last_ring", 1'b1);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk_buzz("last_snz0", 1'b0);
    step();
    step();
    chk_buzz("last_snz2", 1'b0);
    step();
    chk_buzz("last_rering", 1'b1);
    step();
    step();
    step();
    step();
    chk_buzz("last_done", 1'b0);

    // disarm while ringing
    restart_match();
    chk_buzz("off_ring", 1'b1);
    alarmon = 1'b0;
    step();
    chk_buzz("off_stop", 1'b0);
    alarmon = 1'b1;
    step();
    step();
    chk_buzz("off_norearm", 1'b0);

    // entering time-set while ringing
    restart_match();
    chk_buzz("ts_ring", 1'b1);
    timeset = 1'b1;
    step();
    chk_buzz("ts_stop", 1'b0);
    check("ts_mode", {14'd0, mode}, 16'd1);
    timeset = 1'b0;
    step();
    step();
    chk_buzz("ts_norearm", 1'b0);

    // reset mid-snooze
    restart_match();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk_buzz("rst_snz", 1'b0);
    rst = 1'b1;
    alarm_match = 1'b0;
    step();
    chk_buzz("rst_hold", 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk_buzz("rst_quiet", 1'b0);
    check("rst_mode", {14'd0, mode}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
